// File: rtl/regfile_pkg.sv
// regfile_pkg: default register-file geometry and a flat-bus field extractor
package regfile_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;
  localparam int FIELD_MAX = 1024;
  function automatic logic [FIELD_MAX-1:0] field(input logic [FIELD_MAX-1:0] flat, input int w, input int idx);
    return (flat >> (idx * w)) & ~({FIELD_MAX{1'b1}} << w);
  endfunction
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: decode/issue and writeback signals of the scoreboarded register file
interface regfile_mp_sb_if import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
);
  logic [NUM_WR-1:0] wr_en_i;
  logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
  logic [NUM_WR*DATA_W-1:0] wr_data_i;
  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic [NUM_RD-1:0] rd_ready_o;
  logic rsv_en_i;
  logic [ADDR_W-1:0] rsv_addr_i;
  logic flush_i;
  logic [2**ADDR_W-1:0] pending_o;
  modport master(
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, rsv_en_i, rsv_addr_i, flush_i,
    input rd_data_o, rd_ready_o, pending_o
  );
  modport slave(
    input wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, rsv_en_i, rsv_addr_i, flush_i,
    output rd_data_o, rd_ready_o, pending_o
  );
endinterface

// File: rtl/rf_pending_table.sv
// rf_pending_table: per-register pending bits; flush, then releases, then reservation
module rf_pending_table #(
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2
) (
  input logic clk_i,
  input logic rst_i,
  input logic rsv_en_i,
  input logic [ADDR_W-1:0] rsv_addr_i,
  input logic flush_i,
  input logic [NUM_WR-1:0] rel_en_i,
  input logic [ADDR_W-1:0] rel_addr_i [NUM_WR],
  output logic [2**ADDR_W-1:0] pending_o
);
  logic [2**ADDR_W-1:0] nxt;
  always_comb begin
    nxt = flush_i ? '0 : pending_o;
    for (int k = 0; k < NUM_WR; k++)
      if (rel_en_i[k]) nxt[rel_addr_i[k]] = 1'b0;
    // a new producer supersedes any same-cycle release; x0 is never owed
    if (rsv_en_i && rsv_addr_i != '0) nxt[rsv_addr_i] = 1'b1;
  end
  always_ff @(posedge clk_i)
    pending_o <= rst_i ? '0 : nxt;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write forwarding and pending-write scoreboard
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input logic clk_i,
  input logic rst_i,
  regfile_mp_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];
  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wa[k] = ADDR_W'(field(FIELD_MAX'(bus.wr_addr_i), ADDR_W, k));
      wd[k] = DATA_W'(field(FIELD_MAX'(bus.wr_data_i), DATA_W, k));
    end
    for (int r = 0; r < NUM_RD; r++)
      ra[r] = ADDR_W'(field(FIELD_MAX'(bus.rd_addr_i), ADDR_W, r));
  end
  // ascending port order lets the highest-index writer win a same-address conflict
  always_ff @(posedge clk_i) begin
    if (rst_i)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else
      for (int k = 0; k < NUM_WR; k++)
        if (bus.wr_en_i[k] && wa[k] != '0) mem[wa[k]] <= wd[k];
  end
  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_ready_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      bus.rd_data_o[r*DATA_W +: DATA_W] = mem[ra[r]];
      bus.rd_ready_o[r] = !bus.pending_o[ra[r]];
      for (int k = 0; k < NUM_WR; k++)
        if (bus.wr_en_i[k] && wa[k] == ra[r]) begin
          bus.rd_data_o[r*DATA_W +: DATA_W] = wd[k];
          bus.rd_ready_o[r] = 1'b1;
        end
      if (ra[r] == '0) begin
        bus.rd_data_o[r*DATA_W +: DATA_W] = '0;
        bus.rd_ready_o[r] = 1'b1;
      end
    end
  end
  rf_pending_table #(.ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) u_pend (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rsv_en_i(bus.rsv_en_i),
    .rsv_addr_i(bus.rsv_addr_i),
    .flush_i(bus.flush_i),
    .rel_en_i(bus.wr_en_i),
    .rel_addr_i(wa),
    .pending_o(bus.pending_o)
  );
endmodule
